// File: rtl/bbox_extractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bbox_extractor_pkg
//  Description : Shared video timing constants (active area, coordinate
//                width) used by the bounding-box extractor, the overlay
//                stage and the timing generator, plus the extractor FSM
//                state type.
//  Revision    : 1.0  initial release
// ============================================================================
package bbox_extractor_pkg;

   // Shared video geometry
   localparam int VID_COORD_W  = 10;
   localparam int VID_H_ACTIVE = 640;
   localparam int VID_V_ACTIVE = 480;

   // Extractor frame-scan state
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } bbox_state_t;

endpackage : bbox_extractor_pkg
`default_nettype wire

// File: rtl/bbox_extractor_minmax_track.sv
`default_nettype none
// ============================================================================
//  Module      : minmax_track
//  Description : Running minimum/maximum tracker for one coordinate axis.
//                The min/max outputs are look-ahead values: they already
//                fold in this cycle's sample when en is high. This lets the
//                parent latch a frame result in the same cycle as the last
//                sample. init restarts tracking; a sample presented with
//                init becomes the first sample of the new run.
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset
//                init - restart tracking (load initial extremes)
//                en   - val is a sample to track this cycle
//                val  - sample value
//                min  - running minimum including this cycle's sample
//                max  - running maximum including this cycle's sample
//  Revision    : 1.0  initial release
// ============================================================================
module minmax_track #(
   parameter int W        = 10,
   parameter int MIN_INIT = 639
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         init,
   input  logic         en,
   input  logic [W-1:0] val,
   output logic [W-1:0] min,
   output logic [W-1:0] max
);

   localparam logic [W-1:0] c_min_init = W'(MIN_INIT);
   localparam logic [W-1:0] c_max_init = '0;

   logic [W-1:0] r_min;
   logic [W-1:0] r_max;
   logic [W-1:0] w_min_fold;
   logic [W-1:0] w_max_fold;

   assign w_min_fold = (en && (val < r_min)) ? val : r_min;
   assign w_max_fold = (en && (val > r_max)) ? val : r_max;

   assign min = w_min_fold;
   assign max = w_max_fold;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_min <= c_min_init;
         r_max <= c_max_init;
      end else if (init) begin
         r_min <= en ? val : c_min_init;
         r_max <= en ? val : c_max_init;
      end else begin
         r_min <= w_min_fold;
         r_max <= w_max_fold;
      end
   end

endmodule : minmax_track
`default_nettype wire

// File: rtl/bbox_extractor.sv
`default_nettype none
// ============================================================================
//  Module      : bbox_extractor
//  Description : Scans one frame of a 1-bit object mask and reports the
//                bounding box of the set pixels. Results are latched one
//                cycle after frame_end and stay stable until the next
//                completed frame.
//  Ports       : clk         - pixel clock
//                rst         - synchronous active-high reset
//                frame_start - 1-cycle pulse, first cycle of a frame
//                frame_end   - 1-cycle pulse, on/after last active pixel
//                pixel_valid - pixel_x/pixel_y/mask_in meaningful
//                pixel_x/y   - current pixel coordinates
//                mask_in     - 1 = pixel belongs to the object
//                left/right/top/bottom - last reported box
//                box_found   - last frame had >= MIN_PIXELS set pixels
//                bbox_valid  - 1-cycle pulse when outputs were updated
//                pixel_count - saturating set-pixel count of last frame
//  Revision    : 1.0  initial release
// ============================================================================
module bbox_extractor
   import bbox_extractor_pkg::*;
#(
   parameter int COORD_W    = VID_COORD_W,
   parameter int H_ACTIVE   = VID_H_ACTIVE,
   parameter int V_ACTIVE   = VID_V_ACTIVE,
   parameter int MIN_PIXELS = 64,
   parameter int CNT_W      = 19
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_start,
   input  logic               frame_end,
   input  logic               pixel_valid,
   input  logic [COORD_W-1:0] pixel_x,
   input  logic [COORD_W-1:0] pixel_y,
   input  logic               mask_in,
   output logic [COORD_W-1:0] left,
   output logic [COORD_W-1:0] right,
   output logic [COORD_W-1:0] top,
   output logic [COORD_W-1:0] bottom,
   output logic               box_found,
   output logic               bbox_valid,
   output logic [CNT_W-1:0]   pixel_count
);

   localparam logic [COORD_W:0]  c_x_lim   = (COORD_W+1)'(H_ACTIVE);
   localparam logic [COORD_W:0]  c_y_lim   = (COORD_W+1)'(V_ACTIVE);
   localparam logic [CNT_W-1:0]  c_min_pix = CNT_W'(MIN_PIXELS);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   bbox_state_t r_state;
   bbox_state_t w_state_nxt;
   logic        w_init;
   logic        w_latch;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_init      = 1'b0;
      w_latch     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (frame_start) begin
               w_init      = 1'b1;
               w_state_nxt = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (frame_end) begin
               w_latch     = 1'b1;
               w_state_nxt = ST_IDLE;
            end
            // A new frame_start always restarts accumulation, whether or
            // not the current frame is being closed in the same cycle.
            if (frame_start) begin
               w_init      = 1'b1;
               w_state_nxt = ST_ACCUM;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Pixel qualification: a frame_start cycle already belongs to the new
   // frame, so pixels are taken in ACCUM or on any frame_start.
   // ------------------------------------------------------------------
   logic w_in_area;
   logic w_en;

   assign w_in_area = ({1'b0, pixel_x} < c_x_lim) && ({1'b0, pixel_y} < c_y_lim);
   assign w_en      = pixel_valid && mask_in && w_in_area &&
                      ((r_state == ST_ACCUM) || frame_start);

   // ------------------------------------------------------------------
   // Axis trackers (look-ahead outputs include this cycle's pixel)
   // ------------------------------------------------------------------
   logic [COORD_W-1:0] w_min_x;
   logic [COORD_W-1:0] w_max_x;
   logic [COORD_W-1:0] w_min_y;
   logic [COORD_W-1:0] w_max_y;

   minmax_track #(
      .W        (COORD_W),
      .MIN_INIT (H_ACTIVE - 1)
   ) u_track_x (
      .clk  (clk),
      .rst  (rst),
      .init (w_init),
      .en   (w_en),
      .val  (pixel_x),
      .min  (w_min_x),
      .max  (w_max_x)
   );

   minmax_track #(
      .W        (COORD_W),
      .MIN_INIT (V_ACTIVE - 1)
   ) u_track_y (
      .clk  (clk),
      .rst  (rst),
      .init (w_init),
      .en   (w_en),
      .val  (pixel_y),
      .min  (w_min_y),
      .max  (w_max_y)
   );

   // ------------------------------------------------------------------
   // Saturating set-pixel counter; w_cnt_fold includes this cycle's pixel
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_fold;

   assign w_cnt_fold = (w_en && (r_cnt != '1)) ? (r_cnt + CNT_W'(1)) : r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_init) begin
         r_cnt <= w_en ? CNT_W'(1) : '0;
      end else begin
         r_cnt <= w_cnt_fold;
      end
   end

   // ------------------------------------------------------------------
   // Output latch: coordinates only move when a box is actually found
   // ------------------------------------------------------------------
   logic [COORD_W-1:0] r_left;
   logic [COORD_W-1:0] r_right;
   logic [COORD_W-1:0] r_top;
   logic [COORD_W-1:0] r_bottom;
   logic               r_found;
   logic               r_valid;
   logic [CNT_W-1:0]   r_count;
   logic               w_found;

   assign w_found = (w_cnt_fold >= c_min_pix);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_left   <= '0;
         r_right  <= '0;
         r_top    <= '0;
         r_bottom <= '0;
         r_found  <= 1'b0;
         r_valid  <= 1'b0;
         r_count  <= '0;
      end else begin
         r_valid <= w_latch;
         if (w_latch) begin
            r_count <= w_cnt_fold;
            r_found <= w_found;
            if (w_found) begin
               r_left   <= w_min_x;
               r_right  <= w_max_x;
               r_top    <= w_min_y;
               r_bottom <= w_max_y;
            end
         end
      end
   end

   assign left        = r_left;
   assign right       = r_right;
   assign top         = r_top;
   assign bottom      = r_bottom;
   assign box_found   = r_found;
   assign bbox_valid  = r_valid;
   assign pixel_count = r_count;

endmodule : bbox_extractor
`default_nettype wire
